// File: rtl/apb_uart_ctrl_pkg.sv
// apb_uart_ctrl_pkg: UART register map, STATUS bits,
// controller FSM states and APB phase encoding.
package apb_uart_ctrl_pkg;

  localparam logic [3:0] UART_DATA   = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;

  localparam int STAT_RX_NE = 0;
  localparam int STAT_TX_NF = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_SETUP,
    ST_POLL_ACCESS,
    ST_DECIDE,
    ST_XFER_SETUP,
    ST_XFER_ACCESS,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } phase_t;

endpackage

// File: rtl/apb_uart_ctrl_apbm.sv
// apb_uart_ctrl_apbm: single-request APB master, runs
// SETUP then ACCESS and qualifies the read data.
module apb_uart_ctrl_apbm (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic [3:0]  i_addr,
  input  logic        i_write,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic        o_rvalid,
  output logic [7:0]  o_rdata,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [3:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA
);
  import apb_uart_ctrl_pkg::*;

  phase_t      r_phase;
  logic [3:0]  r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic        w_sel;
  logic        w_acc;
  logic        w_unused;

  // phase sequencer: a start may overlap the ACCESS cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= PH_IDLE;
    end else begin
      unique case (r_phase)
        PH_IDLE:   r_phase <= i_start ? PH_SETUP : PH_IDLE;
        PH_SETUP:  r_phase <= PH_ACCESS;
        default:   r_phase <= i_start ? PH_SETUP : PH_IDLE;
      endcase
    end
  end

  // request fields held stable for the whole transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (i_start) begin
      r_addr  <= i_addr;
      r_write <= i_write;
      r_wdata <= i_wdata;
    end
  end

  assign w_sel    = (r_phase != PH_IDLE);
  assign w_acc    = (r_phase == PH_ACCESS);
  assign PSEL     = w_sel;
  assign PENABLE  = w_acc;
  assign PWRITE   = w_sel & r_write;
  assign PADDR    = w_sel ? r_addr : 4'h0;
  assign PWDATA   = w_sel ? r_wdata : 32'h0;
  assign o_done   = w_acc;
  assign o_rvalid = w_acc & ~r_write;
  assign o_rdata  = PRDATA[7:0];
  assign w_unused = ^PRDATA[31:8];

endmodule

// File: rtl/apb_uart_ctrl.sv
// apb_uart_ctrl: polls apb_uart STATUS and moves bytes
// between streams and DATA. Counters: APB_UART_CTRL_STATS_EN.
module apb_uart_ctrl #(
  parameter int   POLL_GAP = 0,
  parameter logic RR_INIT  = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [3:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
);
  import apb_uart_ctrl_pkg::*;

  localparam logic [15:0] GAP_LAST =
    (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_sync;
  logic [1:0]  r_status;
  logic        r_rr;
  logic [15:0] r_gap;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;

  logic        w_go;
  logic        w_tx_ok;
  logic        w_rx_ok;
  logic        w_gnt_tx;
  logic        w_gnt_rx;
  logic        w_start;
  logic [3:0]  w_addr;
  logic        w_write;
  logic [31:0] w_wdata;
  logic        w_done;
  logic        w_rvalid;
  logic [7:0]  w_rdata;

  apb_uart_ctrl_apbm u_apbm (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_start),
    .i_addr   (w_addr),
    .i_write  (w_write),
    .i_wdata  (w_wdata),
    .o_done   (w_done),
    .o_rvalid (w_rvalid),
    .o_rdata  (w_rdata),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA)
  );

  assign w_go     = en & r_sync[1];
  assign w_tx_ok  = r_status[STAT_TX_NF] & tx_valid;
  assign w_rx_ok  = r_status[STAT_RX_NE] & ~r_rx_valid;
  assign w_gnt_tx = (r_state == ST_DECIDE) & w_tx_ok
                  & (~w_rx_ok | ~r_rr);
  assign w_gnt_rx = (r_state == ST_DECIDE) & w_rx_ok
                  & (~w_tx_ok | r_rr);

  assign tx_ready = w_gnt_tx;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = (r_state != ST_IDLE);

  // reset release synchroniser gating the exit from IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], 1'b1};
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // next state and APB request issue
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_addr  = UART_STATUS;
    w_write = 1'b0;
    w_wdata = 32'h0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_next  = ST_POLL_SETUP;
          w_start = 1'b1;
        end
      end
      ST_POLL_SETUP: w_next = ST_POLL_ACCESS;
      ST_POLL_ACCESS: begin
        if (w_done) w_next = ST_DECIDE;
      end
      ST_DECIDE: begin
        unique case (1'b1)
          w_gnt_tx: begin
            w_next  = ST_XFER_SETUP;
            w_start = 1'b1;
            w_addr  = UART_DATA;
            w_write = 1'b1;
            w_wdata = {24'h0, tx_data};
          end
          w_gnt_rx: begin
            w_next  = ST_XFER_SETUP;
            w_start = 1'b1;
            w_addr  = UART_DATA;
          end
          default: begin
            w_next = (POLL_GAP == 0) ? ST_IDLE : ST_GAP;
          end
        endcase
      end
      ST_XFER_SETUP: w_next = ST_XFER_ACCESS;
      ST_XFER_ACCESS: begin
        if (w_done) begin
          if (w_go) begin
            w_next  = ST_POLL_SETUP;
            w_start = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_LAST) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // round-robin pointer flips only on a real tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr <= RR_INIT;
    end else if (r_state == ST_DECIDE
                 && w_tx_ok && w_rx_ok) begin
      r_rr <= ~r_rr;
    end
  end

  // idle gap counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_gap <= '0;
    else if (r_state == ST_GAP) r_gap <= r_gap + 16'd1;
    else                        r_gap <= '0;
  end

  // STATUS snapshot taken at the end of the poll read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_status <= 2'b00;
    end else if (r_state == ST_POLL_ACCESS && w_rvalid) begin
      r_status <= w_rdata[1:0];
    end
  end

  // one-deep receive holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else if (r_state == ST_XFER_ACCESS && w_rvalid) begin
      r_rx_data  <= w_rdata;
      r_rx_valid <= 1'b1;
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

`ifdef APB_UART_CTRL_STATS_EN
  logic [15:0] r_tx_cnt;
  logic [15:0] r_rx_cnt;

  // completed transfer counters, wrapping at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else if (r_state == ST_XFER_ACCESS && w_done) begin
      if (w_rvalid) r_rx_cnt <= r_rx_cnt + 16'd1;
      else          r_tx_cnt <= r_tx_cnt + 16'd1;
    end
  end

  assign tx_count = r_tx_cnt;
  assign rx_count = r_rx_cnt;
`else
  assign tx_count = 16'h0;
  assign rx_count = 16'h0;
`endif

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// tb_apb_uart_ctrl: directed-random bench with a queue
// based apb_uart slave and byte-stream source/sink.
module tb_apb_uart_ctrl;

  localparam int GAP = 4;
`ifdef APB_UART_CTRL_STATS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        busy;
  logic [15:0] tx_count;
  logic [15:0] rx_count;

  always #5 clk = ~clk;

  apb_uart_ctrl #(.POLL_GAP(GAP), .RR_INIT(1'b0)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .tx_count (tx_count),
    .rx_count (rx_count)
  );

  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;
  int data_rd = 0;

  logic [7:0] rxq[$];
  logic [7:0] src[$];
  logic [7:0] wlog[$];
  logic [7:0] got[$];
  logic [7:0] exp_b[$];
  bit         xlog[$];
  int         poll_t[$];
  int         wacc_t[$];

  bit         tx_full = 1'b0;
  bit         loopback = 1'b0;
  bit         rdy_on = 1'b1;
  bit         drop_hook = 1'b0;
  logic [7:0] hook_byte = 8'h00;
  bit         rst_hook = 1'b0;
  bit         rst_fired = 1'b0;
  logic       snap_psel;
  logic       snap_pen;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    src.push_back(b);
    tx_valid = 1'b1;
    tx_data  = src[0];
  endtask

  // one clock: slave response and logging at negedge,
  // source/sink updates just after posedge
  task automatic cyc();
    logic [31:0] junk;
    bit tx_acc;
    bit rx_acc;
    @(negedge clk);
    ncyc++;
    junk   = $urandom();
    PRDATA = 32'h0;
    if (PSEL && !PWRITE) begin
      if (PADDR == 4'h4)
        PRDATA = {junk[31:2], ~tx_full, rxq.size() != 0};
      else if (PADDR == 4'h0)
        PRDATA = {junk[31:8], (rxq.size() != 0) ? rxq[0] : 8'h00};
    end
    tx_acc = tx_ready && tx_valid;
    rx_acc = rx_valid && rx_ready;
    if (rx_acc) got.push_back(rx_data);
    if (PSEL && !PENABLE && PADDR == 4'h4) begin
      poll_t.push_back(ncyc);
      if (drop_hook) begin
        drop_hook = 1'b0;
        en = 1'b0;
        push_tx(hook_byte);
      end
    end
    if (rst_hook && PSEL && PENABLE && PADDR == 4'h0) begin
      rst_hook = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      snap_psel = PSEL;
      snap_pen  = PENABLE;
      rst_fired = 1'b1;
    end else if (PSEL && PENABLE) begin
      if (PWRITE) begin
        wlog.push_back(PWDATA[7:0]);
        xlog.push_back(1'b1);
        wacc_t.push_back(ncyc);
        if (loopback) rxq.push_back(PWDATA[7:0]);
      end else if (PADDR == 4'h0) begin
        xlog.push_back(1'b0);
        data_rd++;
        if (rxq.size() != 0) void'(rxq.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (tx_acc && src.size() != 0) void'(src.pop_front());
    tx_valid = (src.size() != 0);
    tx_data  = tx_valid ? src[0] : 8'h00;
    rx_ready = rdy_on;
  endtask

  initial begin
    int k;
    int pt;
    int rd0;
    logic [7:0] b;
    logic [7:0] tx_b[$];
    logic [7:0] rx_b[$];

    reset_n  = 1'b0;
    en       = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b1;
    PRDATA   = 32'h0;

    // preload a tie: both streams have work on the first poll
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom());
      tx_b.push_back(b);
      push_tx(b);
      b = 8'($urandom());
      rx_b.push_back(b);
      rxq.push_back(b);
    end
    repeat (3) cyc();

    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_counts", {tx_count, rx_count}, 0);

    // round-robin ties: TX, RX, TX, ... from RR_INIT=0
    reset_n = 1'b1;
    en      = 1'b1;
    k = 0;
    while ((xlog.size() < 8 || got.size() < 4) && k < 300) begin
      cyc();
      k++;
    end
    chk("rr_done", 32'(xlog.size() >= 8 && got.size() >= 4), 1);
    for (int i = 0; i < 8 && i < xlog.size(); i++)
      chk($sformatf("rr_order%0d", i), xlog[i], (i % 2 == 0));
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      chk($sformatf("rr_tx%0d", i), wlog[i], tx_b[i]);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("rr_rx%0d", i), got[i], rx_b[i]);
    chk("rr_cnt", {tx_count, rx_count},
        ST ? {16'd4, 16'd4} : 32'h0);

    // idle polling cadence: 3 poll/decide + GAP + 1 IDLE
    repeat (20) cyc();
    poll_t.delete();
    k = xlog.size();
    repeat (48) cyc();
    chk("gap_polls", 32'(poll_t.size() >= 4), 1);
    for (int i = 0; i + 1 < poll_t.size() && i < 3; i++)
      chk($sformatf("gap_space%0d", i),
          poll_t[i + 1] - poll_t[i], 3 + GAP + 1);
    chk("gap_noxfer", xlog.size(), k);

    // TX latency and steady-state rate
    wlog.delete();
    wacc_t.delete();
    poll_t.delete();
    exp_b.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom());
      exp_b.push_back(b);
      push_tx(b);
    end
    k = 0;
    while (wlog.size() < 3 && k < 100) begin
      cyc();
      k++;
    end
    chk("tx3_done", wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++)
      chk($sformatf("tx3_byte%0d", i), wlog[i], exp_b[i]);
    if (wacc_t.size() >= 3) begin
      pt = 0;
      foreach (poll_t[i]) if (poll_t[i] <= wacc_t[0]) pt = poll_t[i];
      chk("tx_latency", wacc_t[0] - pt, 4);
      chk("tx_rate1", wacc_t[1] - wacc_t[0], 5);
      chk("tx_rate2", wacc_t[2] - wacc_t[1], 5);
    end

    // TX FIFO full holds the byte back
    tx_full = 1'b1;
    repeat (12) cyc();
    wlog.delete();
    b = 8'($urandom());
    push_tx(b);
    repeat (30) cyc();
    chk("txfull_hold", wlog.size(), 0);
    tx_full = 1'b0;
    k = 0;
    while (wlog.size() < 1 && k < 60) begin
      cyc();
      k++;
    end
    chk("txfull_release", (wlog.size() != 0) ? wlog[0] : 8'hxx, b);

    // loopback stream AB CD EF
    loopback = 1'b1;
    got.delete();
    push_tx(8'hAB);
    push_tx(8'hCD);
    push_tx(8'hEF);
    k = 0;
    while (got.size() < 3 && k < 300) begin
      cyc();
      k++;
    end
    chk("loop_n", got.size(), 3);
    chk("loop_b0", (got.size() > 0) ? got[0] : 8'hxx, 8'hAB);
    chk("loop_b1", (got.size() > 1) ? got[1] : 8'hxx, 8'hCD);
    chk("loop_b2", (got.size() > 2) ? got[2] : 8'hxx, 8'hEF);
    chk("loop_cnt", {tx_count, rx_count},
        ST ? {16'd11, 16'd7} : 32'h0);

    // sink back-pressure: a single DATA read, then held
    rdy_on   = 1'b0;
    rx_ready = 1'b0;
    got.delete();
    wlog.delete();
    exp_b.delete();
    rd0 = data_rd;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom());
      exp_b.push_back(b);
      push_tx(b);
    end
    repeat (150) cyc();
    chk("bp_one_read", data_rd - rd0, 1);
    chk("bp_rx_valid", rx_valid, 1);
    chk("bp_rx_data", rx_data, exp_b[0]);
    chk("bp_all_written", wlog.size(), 10);
    rdy_on = 1'b1;
    k = 0;
    while (got.size() < 10 && k < 400) begin
      cyc();
      k++;
    end
    chk("bp_n", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk($sformatf("bp_b%0d", i), got[i], exp_b[i]);
    chk("bp_cnt", {tx_count, rx_count},
        ST ? {16'd21, 16'd17} : 32'h0);
    loopback = 1'b0;

    // en dropped inside POLL_SETUP: that round still completes
    repeat (20) cyc();
    wlog.delete();
    poll_t.delete();
    hook_byte = 8'($urandom());
    drop_hook = 1'b1;
    repeat (50) cyc();
    chk("endrop_polls", poll_t.size(), 1);
    chk("endrop_wr", wlog.size(), 1);
    chk("endrop_byte", (wlog.size() != 0) ? wlog[0] : 8'hxx, hook_byte);
    chk("endrop_busy", busy, 0);
    chk("endrop_psel", PSEL, 0);

    // reset in XFER_ACCESS: first byte lost, second survives
    wlog.delete();
    exp_b.delete();
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom());
      exp_b.push_back(b);
      push_tx(b);
    end
    rst_hook = 1'b1;
    en = 1'b1;
    k = 0;
    while (!rst_fired && k < 60) begin
      cyc();
      k++;
    end
    chk("xrst_fired", rst_fired, 1);
    chk("xrst_async", {snap_psel, snap_pen}, 2'b00);
    chk("xrst_ctl",
        {PSEL, PENABLE, PWRITE, tx_ready, rx_valid, busy}, 0);
    chk("xrst_paddr", PADDR, 0);
    chk("xrst_pwdata", PWDATA, 0);
    chk("xrst_rx_data", rx_data, 0);
    chk("xrst_cnt", {tx_count, rx_count}, 0);
    reset_n = 1'b1;
    k = 0;
    while (wlog.size() < 1 && k < 80) begin
      cyc();
      k++;
    end
    repeat (20) cyc();
    chk("xrst_wr_n", wlog.size(), 1);
    chk("xrst_byte", (wlog.size() != 0) ? wlog[0] : 8'hxx, exp_b[1]);
    chk("xrst_cnt2", {tx_count, rx_count},
        ST ? {16'd1, 16'd0} : 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
